// File: rtl/collision_scanner_if.sv
// rtl/collision_scanner_if.sv - scan request, snapshot inputs, results and draw-mux bundle
//
// Purpose: groups every non-clock/reset signal of collision_scanner.
//   master: game logic side (drives start, positions, clearSticky, object)
//   slave : collision_scanner side (drives busy, done, results, oX/oY)
// Signals:
//   start, rocketX/Y, objX/Y (packed per object), objActive, clearSticky, object
//   busy, done, collisionOccured, hitMask, firstHit, hitCount, stickyCollision, oX, oY
interface collision_scanner_if #(
  parameter int NUM_OBJ = 8,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
  parameter int CNT_W   = $clog2(NUM_OBJ + 1)
);
  logic                   start;
  logic [X_W-1:0]         rocketX;
  logic [Y_W-1:0]         rocketY;
  logic [NUM_OBJ*X_W-1:0] objX;
  logic [NUM_OBJ*Y_W-1:0] objY;
  logic [NUM_OBJ-1:0]     objActive;
  logic                   clearSticky;
  logic [7:0]             object;

  logic                   busy;
  logic                   done;
  logic                   collisionOccured;
  logic [NUM_OBJ-1:0]     hitMask;
  logic [IDX_W-1:0]       firstHit;
  logic [CNT_W-1:0]       hitCount;
  logic                   stickyCollision;
  logic [X_W-1:0]         oX;
  logic [Y_W-1:0]         oY;

  modport master (
    output start, rocketX, rocketY, objX, objY, objActive, clearSticky, object,
    input  busy, done, collisionOccured, hitMask, firstHit, hitCount,
           stickyCollision, oX, oY
  );

  modport slave (
    input  start, rocketX, rocketY, objX, objY, objActive, clearSticky, object,
    output busy, done, collisionOccured, hitMask, firstHit, hitCount,
           stickyCollision, oX, oY
  );
endinterface

// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - sequential rocket-vs-object hitbox scanner with draw mux
//
// Purpose: on start, snapshots rocket and object positions and tests one object
// per clock against the rocket hitbox (inclusive edges, no coordinate wrap).
// After NUM_OBJ cycles the hit mask, lowest hit index, hit count and collision
// flag are committed with a one-cycle done pulse. A sticky flag records any hit
// until clearSticky. Also muxes the position selected by 'object' for drawing.
// Ports:
//   Clock  - system clock
//   Reset  - synchronous, active-low reset
//   bus    - collision_scanner_if slave modport (request, positions, results, draw mux)
module collision_scanner #(
  parameter int NUM_OBJ  = 8,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int ROCKET_W = 7,
  parameter int ROCKET_H = 15,
  parameter int OBJ_W    = 4,
  parameter int OBJ_H    = 4,
  parameter int IDX_W    = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1,
  parameter int CNT_W    = $clog2(NUM_OBJ + 1)
) (
  input logic               Clock,
  input logic               Reset,
  collision_scanner_if.slave bus
);

  // Right/bottom edge offsets, held one bit wider than the coordinates so
  // edge sums never wrap.
  localparam logic [X_W:0]       RKT_DX   = (X_W + 1)'(ROCKET_W - 1);
  localparam logic [Y_W:0]       RKT_DY   = (Y_W + 1)'(ROCKET_H - 1);
  localparam logic [X_W:0]       OBJ_DX   = (X_W + 1)'(OBJ_W - 1);
  localparam logic [Y_W:0]       OBJ_DY   = (Y_W + 1)'(OBJ_H - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_OBJ - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state;
  logic [X_W-1:0]         snap_rx;
  logic [Y_W-1:0]         snap_ry;
  logic [NUM_OBJ*X_W-1:0] snap_ox;
  logic [NUM_OBJ*Y_W-1:0] snap_oy;
  logic [NUM_OBJ-1:0]     snap_act;
  logic [IDX_W-1:0]       idx;

  // Running results for the scan in progress.
  logic [NUM_OBJ-1:0]     work_mask;
  logic [CNT_W-1:0]       work_cnt;
  logic [IDX_W-1:0]       work_first;
  logic                   work_found;

  logic                   busy_r;
  logic                   done_r;
  logic                   coll_r;
  logic [NUM_OBJ-1:0]     mask_r;
  logic [IDX_W-1:0]       first_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   sticky_r;

  logic [X_W-1:0]         cur_ox;
  logic [Y_W-1:0]         cur_oy;
  logic                   cur_act;
  logic                   hit;
  logic                   last;
  logic [NUM_OBJ-1:0]     nxt_mask;
  logic [CNT_W-1:0]       nxt_cnt;
  logic [IDX_W-1:0]       nxt_first;
  logic                   nxt_found;

  // Select the snapshot entry under test.
  always_comb begin
    cur_ox  = '0;
    cur_oy  = '0;
    cur_act = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_ox  = snap_ox[i*X_W +: X_W];
        cur_oy  = snap_oy[i*Y_W +: Y_W];
        cur_act = snap_act[i];
      end
    end
  end

  assign hit = cur_act
             && ({1'b0, snap_rx} <= ({1'b0, cur_ox} + OBJ_DX))
             && ({1'b0, cur_ox}  <= ({1'b0, snap_rx} + RKT_DX))
             && ({1'b0, snap_ry} <= ({1'b0, cur_oy} + OBJ_DY))
             && ({1'b0, cur_oy}  <= ({1'b0, snap_ry} + RKT_DY));

  assign last      = (idx == LAST_IDX);
  assign nxt_mask  = work_mask | (NUM_OBJ'(hit) << idx);
  assign nxt_cnt   = work_cnt + CNT_W'(hit);
  assign nxt_found = work_found | hit;
  // The first hit is latched once; later hits leave it alone.
  assign nxt_first = work_found ? work_first : (hit ? idx : '0);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state      <= IDLE;
      snap_rx    <= '0;
      snap_ry    <= '0;
      snap_ox    <= '0;
      snap_oy    <= '0;
      snap_act   <= '0;
      idx        <= '0;
      work_mask  <= '0;
      work_cnt   <= '0;
      work_first <= '0;
      work_found <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      coll_r     <= 1'b0;
      mask_r     <= '0;
      first_r    <= '0;
      cnt_r      <= '0;
      sticky_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            snap_rx    <= bus.rocketX;
            snap_ry    <= bus.rocketY;
            snap_ox    <= bus.objX;
            snap_oy    <= bus.objY;
            snap_act   <= bus.objActive;
            idx        <= '0;
            work_mask  <= '0;
            work_cnt   <= '0;
            work_first <= '0;
            work_found <= 1'b0;
            busy_r     <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (last) begin
            mask_r  <= nxt_mask;
            cnt_r   <= nxt_cnt;
            first_r <= nxt_first;
            coll_r  <= nxt_found;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end else begin
            work_mask  <= nxt_mask;
            work_cnt   <= nxt_cnt;
            work_first <= nxt_first;
            work_found <= nxt_found;
            idx        <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // A commit with a hit outranks a simultaneous clear.
      if (state == SCAN && last && nxt_found)
        sticky_r <= 1'b1;
      else if (bus.clearSticky)
        sticky_r <= 1'b0;
    end
  end

  assign bus.busy             = busy_r;
  assign bus.done             = done_r;
  assign bus.collisionOccured = coll_r;
  assign bus.hitMask          = mask_r;
  assign bus.firstHit         = first_r;
  assign bus.hitCount         = cnt_r;
  assign bus.stickyCollision  = sticky_r;

  // Draw mux on live inputs: 1 = rocket, 2..NUM_OBJ+1 = object (object-2).
  always_comb begin
    bus.oX = '0;
    bus.oY = '0;
    if (bus.object == 8'd1) begin
      bus.oX = bus.rocketX;
      bus.oY = bus.rocketY;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (bus.object == 8'(i + 2)) begin
          bus.oX = bus.objX[i*X_W +: X_W];
          bus.oY = bus.objY[i*Y_W +: Y_W];
        end
      end
    end
  end

endmodule
